// File: rtl/gbe_ctr_arb_pkg.sv
// Shared types and constants for the gbe counter OPB arbiter.
package gbe_ctr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CLRALL,
    ST_ACK,
    ST_HOLD
  } state_e;

  localparam logic [5:0]  CTRL_OFF   = 6'd16;
  localparam logic [5:0]  STATUS_OFF = 6'd17;
  localparam logic [31:0] TOUT_DATA  = 32'hDEADBEEF;

endpackage

// File: rtl/opb_addr_decode.sv
// OPB window decode: hit flag and word offset within a 256-byte window.
module opb_addr_decode #(
  parameter logic [31:0] C_BASEADDR = 32'h01088000,
  parameter logic [31:0] C_HIGHADDR = 32'h010880FF
) (
  input  logic        opb_select,
  input  logic [0:31] opb_abus,
  output logic        hit,
  output logic [5:0]  word_off
);

  assign hit      = opb_select && (opb_abus >= C_BASEADDR) && (opb_abus <= C_HIGHADDR);
  assign word_off = opb_abus[24:29];

endmodule

// File: rtl/opb_gbe_ctr_arbiter.sv
// Single OPB slave fronting all gbe status counters with a req/ack read handshake.
// Optional timeout STATUS register is enabled by defining CTR_ARB_TOUT_STATUS_EN.
module opb_gbe_ctr_arbiter
  import gbe_ctr_arb_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR  = 32'h01088000,
  parameter logic [31:0] C_HIGHADDR  = 32'h010880FF,
  parameter int          N_CTR       = 4,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic        Sl_xferAck,
  output logic        ctr_req,
  output logic [3:0]  ctr_idx,
  input  logic        ctr_ack,
  input  logic [31:0] ctr_data,
  output logic        ctr_clr
);

  localparam logic [5:0] N_CTR_W   = 6'(N_CTR);
  localparam logic [3:0] LAST_IDX  = 4'(N_CTR - 1);
  localparam logic [7:0] TOUT_LAST = 8'(ACK_TIMEOUT - 1);

  logic       hit;
  logic [5:0] word_off;
  logic       is_ctr;
  logic       unused_inputs;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [7:0]  tout_q, tout_d;
`ifdef CTR_ARB_TOUT_STATUS_EN
  logic [7:0]  tout_cnt_q, tout_cnt_d;
  logic [3:0]  last_tout_idx_q, last_tout_idx_d;
`endif

  opb_addr_decode #(
    .C_BASEADDR(C_BASEADDR),
    .C_HIGHADDR(C_HIGHADDR)
  ) u_decode (
    .opb_select(OPB_select),
    .opb_abus  (OPB_ABus),
    .hit       (hit),
    .word_off  (word_off)
  );

  assign is_ctr        = (word_off < N_CTR_W);
  assign Sl_retry      = 1'b0;
  assign unused_inputs = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:30]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    err_d      = err_q;
    tout_d     = tout_q;
`ifdef CTR_ARB_TOUT_STATUS_EN
    tout_cnt_d      = tout_cnt_q;
    last_tout_idx_d = last_tout_idx_q;
`endif
    ctr_req    = 1'b0;
    ctr_clr    = 1'b0;
    ctr_idx    = 4'd0;
    Sl_xferAck = 1'b0;
    Sl_errAck  = 1'b0;
    Sl_DBus    = '0;
    Sl_toutSup = 1'b0;

    case (state_q)
      ST_IDLE: begin
        err_d  = 1'b0;
        tout_d = '0;
        data_d = '0;
        if (hit) begin
          if (is_ctr) begin
            idx_d = word_off[3:0];
            if (OPB_RNW) begin
              state_d = ST_REQ;
            end else begin
              // Single clear is issued straight from IDLE so the ack follows next cycle
              ctr_clr = 1'b1;
              ctr_idx = word_off[3:0];
              state_d = ST_ACK;
            end
          end else if (word_off == CTRL_OFF && !OPB_RNW && OPB_DBus[31]) begin
            idx_d   = '0;
            state_d = ST_CLRALL;
          end else begin
`ifdef CTR_ARB_TOUT_STATUS_EN
            if (word_off == STATUS_OFF) begin
              if (OPB_RNW) begin
                data_d = {8'h00, tout_cnt_q, 12'h000, last_tout_idx_q};
              end else begin
                tout_cnt_d      = '0;
                last_tout_idx_d = '0;
              end
            end
`endif
            state_d = ST_ACK;
          end
        end
      end
      ST_REQ: begin
        ctr_req    = 1'b1;
        ctr_idx    = idx_q;
        Sl_toutSup = 1'b1;
        state_d    = OPB_select ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        Sl_toutSup = 1'b1;
        // Master abort beats everything; a late ack beats the timeout
        if (!OPB_select) begin
          state_d = ST_IDLE;
        end else if (ctr_ack) begin
          data_d  = ctr_data;
          state_d = ST_ACK;
        end else if (tout_q == TOUT_LAST) begin
          data_d  = TOUT_DATA;
          err_d   = 1'b1;
          state_d = ST_ACK;
`ifdef CTR_ARB_TOUT_STATUS_EN
          if (tout_cnt_q != 8'hFF) tout_cnt_d = tout_cnt_q + 8'd1;
          last_tout_idx_d = idx_q;
`endif
        end else begin
          tout_d = tout_q + 8'd1;
        end
      end
      ST_CLRALL: begin
        ctr_clr    = 1'b1;
        ctr_idx    = idx_q;
        Sl_toutSup = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_ACK;
        else                   idx_d   = idx_q + 4'd1;
      end
      ST_ACK: begin
        Sl_xferAck = 1'b1;
        Sl_errAck  = err_q;
        Sl_DBus    = data_q;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (!OPB_select) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tout_q  <= '0;
`ifdef CTR_ARB_TOUT_STATUS_EN
      tout_cnt_q      <= '0;
      last_tout_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
`ifdef CTR_ARB_TOUT_STATUS_EN
      tout_cnt_q      <= tout_cnt_d;
      last_tout_idx_q <= last_tout_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_opb_gbe_ctr_arbiter.sv
// Self-checking bench for opb_gbe_ctr_arbiter: directed and random OPB transactions
// compared against a transaction-level model of the counter window.
module tb_opb_gbe_ctr_arbiter;

  localparam logic [31:0] BASE = 32'h01088000;
  localparam logic [31:0] HIGH = 32'h010880FF;
  localparam int          NC   = 4;
  localparam int          TO   = 16;
  localparam int          MAXC = TO + 24;

  logic        OPB_Clk;
  logic        OPB_Rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;
  logic        ctr_req;
  logic [3:0]  ctr_idx;
  logic        ctr_ack;
  logic [31:0] ctr_data;
  logic        ctr_clr;

  int checks   = 0;
  int failures = 0;

  // observations of one transaction
  int          o_ack_count, o_ack_cycle, o_req_count, o_req_cycle, o_req_idx;
  logic [31:0] o_data;
  logic        o_err, o_any, o_tsup;
  int          o_clr_cycle[$];
  int          o_clr_idx[$];

  // model of the optional timeout status register
  int m_tout_cnt = 0;
  int m_last_idx = 0;

  opb_gbe_ctr_arbiter #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .N_CTR      (NC),
    .ACK_TIMEOUT(TO)
  ) dut (
    .OPB_Clk    (OPB_Clk),
    .OPB_Rst_n  (OPB_Rst_n),
    .OPB_ABus   (OPB_ABus),
    .OPB_BE     (OPB_BE),
    .OPB_DBus   (OPB_DBus),
    .OPB_RNW    (OPB_RNW),
    .OPB_select (OPB_select),
    .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus    (Sl_DBus),
    .Sl_errAck  (Sl_errAck),
    .Sl_retry   (Sl_retry),
    .Sl_toutSup (Sl_toutSup),
    .Sl_xferAck (Sl_xferAck),
    .ctr_req    (ctr_req),
    .ctr_idx    (ctr_idx),
    .ctr_ack    (ctr_ack),
    .ctr_data   (ctr_data),
    .ctr_clr    (ctr_clr)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one OPB transfer starting just after a rising edge (cycle 0 = select asserted).
  // The bank answers ack_delay cycles after ctr_req (0 = never).
  task automatic applyStimulus(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                               input int ack_delay, input logic [31:0] bank_val,
                               input int hold, input int abort_at);
    o_ack_count = 0; o_ack_cycle = -1; o_req_count = 0; o_req_cycle = -1; o_req_idx = -1;
    o_data = '0; o_err = 1'b0; o_any = 1'b0; o_tsup = 1'b0;
    o_clr_cycle.delete(); o_clr_idx.delete();
    OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wdata; OPB_select = 1'b1;
    OPB_BE = 4'($urandom); OPB_seqAddr = 1'($urandom);
    for (int c = 0; c < MAXC; c++) begin
      ctr_ack  = (o_req_cycle >= 0 && ack_delay > 0 && c == o_req_cycle + ack_delay);
      ctr_data = ctr_ack ? bank_val : $urandom;
      @(negedge OPB_Clk);
      if (ctr_req) begin
        o_req_count++; o_req_cycle = c; o_req_idx = int'(ctr_idx); o_tsup = Sl_toutSup;
      end
      if (ctr_clr) begin
        o_clr_cycle.push_back(c); o_clr_idx.push_back(int'(ctr_idx));
      end
      if (Sl_xferAck) begin
        o_ack_count++;
        if (o_ack_cycle < 0) begin
          o_ack_cycle = c; o_data = Sl_DBus; o_err = Sl_errAck;
        end
      end
      if (Sl_xferAck || Sl_errAck || ctr_req || ctr_clr || Sl_toutSup || Sl_retry ||
          (Sl_DBus != 0) || (ctr_idx != 0)) o_any = 1'b1;
      @(posedge OPB_Clk); #1;
      if (abort_at >= 0 && c + 1 >= abort_at) OPB_select = 1'b0;
      if (o_ack_cycle >= 0 && c + 1 > o_ack_cycle + hold) OPB_select = 1'b0;
    end
    ctr_ack = 1'b0;
    OPB_select = 1'b0;
  endtask

  // Expected behaviour derived from the address map and handshake timing rules.
  task automatic expectTransaction(input string tag, input logic [31:0] addr, input logic rnw,
                                   input logic [31:0] wdata, input int ack_delay,
                                   input logic [31:0] bank_val, input int abort_at);
    int          word;
    int          exp_cycle;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        aborted;
    if (addr < BASE || addr > HIGH) begin
      checkOutput({tag, ".outside_acks"}, o_ack_count, 0);
      checkOutput({tag, ".outside_quiet"}, 32'(o_any), 0);
      return;
    end
    word     = int'((addr - BASE) >> 2);
    exp_data = '0;
    exp_err  = 1'b0;
    if (word < NC && rnw) begin
      checkOutput({tag, ".req_count"}, o_req_count, 1);
      checkOutput({tag, ".req_cycle"}, o_req_cycle, 1);
      checkOutput({tag, ".req_idx"}, o_req_idx, word);
      checkOutput({tag, ".req_toutsup"}, 32'(o_tsup), 1);
      if (ack_delay >= 1 && ack_delay <= TO) begin
        exp_cycle = 2 + ack_delay; exp_data = bank_val;
      end else begin
        exp_cycle = 2 + TO; exp_data = 32'hDEADBEEF; exp_err = 1'b1;
      end
      aborted = (abort_at >= 1 && abort_at < exp_cycle);
      if (aborted) begin
        checkOutput({tag, ".abort_acks"}, o_ack_count, 0);
        return;
      end
      if (exp_err) begin
        m_tout_cnt = (m_tout_cnt < 255) ? m_tout_cnt + 1 : 255;
        m_last_idx = word;
      end
    end else if (word < NC) begin
      checkOutput({tag, ".clr_count"}, o_clr_cycle.size(), 1);
      if (o_clr_cycle.size() == 1) begin
        checkOutput({tag, ".clr_cycle"}, o_clr_cycle[0], 0);
        checkOutput({tag, ".clr_idx"}, o_clr_idx[0], word);
      end
      exp_cycle = 1;
    end else if (word == 16 && !rnw && wdata[0]) begin
      checkOutput({tag, ".clrall_count"}, o_clr_cycle.size(), NC);
      for (int i = 0; i < o_clr_cycle.size() && i < NC; i++) begin
        checkOutput({tag, ".clrall_cycle"}, o_clr_cycle[i], i + 1);
        checkOutput({tag, ".clrall_idx"}, o_clr_idx[i], i);
      end
      exp_cycle = NC + 1;
    end else begin
      exp_cycle = 1;
      checkOutput({tag, ".no_clr"}, o_clr_cycle.size(), 0);
`ifdef CTR_ARB_TOUT_STATUS_EN
      if (word == 17) begin
        if (rnw) exp_data = {8'h00, 8'(m_tout_cnt), 12'h000, 4'(m_last_idx)};
        else begin m_tout_cnt = 0; m_last_idx = 0; end
      end
`endif
    end
    checkOutput({tag, ".ack_count"}, o_ack_count, 1);
    checkOutput({tag, ".ack_cycle"}, o_ack_cycle, exp_cycle);
    checkOutput({tag, ".data"}, o_data, exp_data);
    checkOutput({tag, ".err"}, 32'(o_err), 32'(exp_err));
  endtask

  task automatic doTxn(input string tag, input logic [31:0] addr, input logic rnw,
                       input logic [31:0] wdata, input int ack_delay, input logic [31:0] bank_val,
                       input int hold, input int abort_at);
    applyStimulus(addr, rnw, wdata, ack_delay, bank_val, hold, abort_at);
    expectTransaction(tag, addr, rnw, wdata, ack_delay, bank_val, abort_at);
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, ".xferAck"}, 32'(Sl_xferAck), 0);
    checkOutput({tag, ".errAck"}, 32'(Sl_errAck), 0);
    checkOutput({tag, ".DBus"}, Sl_DBus, 0);
    checkOutput({tag, ".toutSup"}, 32'(Sl_toutSup), 0);
    checkOutput({tag, ".retry"}, 32'(Sl_retry), 0);
    checkOutput({tag, ".ctr_req"}, 32'(ctr_req), 0);
    checkOutput({tag, ".ctr_clr"}, 32'(ctr_clr), 0);
    checkOutput({tag, ".ctr_idx"}, 32'(ctr_idx), 0);
  endtask

  initial begin
    logic [31:0] addr;
    logic        rnw;
    int          kind, delay, abort_at;

    $display("[TB] start");
    OPB_Rst_n = 1'b0; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; ctr_ack = 1'b0; ctr_data = '0;
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    checkAllIdle("reset");
    @(posedge OPB_Clk); #1;
    OPB_Rst_n = 1'b1;
    @(posedge OPB_Clk); #1;

    doTxn("rd_ctr2", BASE + 32'h8, 1'b1, 0, 1, 32'h00000123, 0, -1);
    doTxn("rd_ctr1_tout", BASE + 32'h4, 1'b1, 0, 0, 32'h0, 1, -1);
    doTxn("rd_status", BASE + 32'h44, 1'b1, 0, 0, 32'h0, 0, -1);
    doTxn("wr_ctrl", BASE + 32'h40, 1'b0, 32'h1, 0, 32'h0, 0, -1);
    doTxn("wr_ctr3_hold", BASE + 32'hC, 1'b0, 32'h0, 0, 32'h0, 5, -1);
    doTxn("rd_word9", BASE + 32'h24, 1'b1, 0, 0, 32'h0, 0, -1);
    doTxn("rd_outside_hi", HIGH + 32'h1, 1'b1, 0, 1, 32'h5, 0, -1);
    doTxn("rd_outside_lo", BASE - 32'h4, 1'b1, 0, 1, 32'h5, 0, -1);
    doTxn("wr_ctrl_bit0_0", BASE + 32'h40, 1'b0, 32'hFFFFFFFE, 0, 32'h0, 0, -1);
    doTxn("rd_ack_at_limit", BASE + 32'h0, 1'b1, 0, TO, 32'hCAFE0001, 0, -1);
    doTxn("rd_ack_late", BASE + 32'h0, 1'b1, 0, TO + 1, 32'hCAFE0002, 0, -1);
    doTxn("rd_abort_wait", BASE + 32'h8, 1'b1, 0, 0, 32'h0, 0, 5);
    doTxn("wr_status", BASE + 32'h44, 1'b0, 32'h0, 0, 32'h0, 0, -1);
    doTxn("rd_status_clr", BASE + 32'h44, 1'b1, 0, 0, 32'h0, 0, -1);

    // reset while waiting for the bank
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_select = 1'b1;
    repeat (4) @(posedge OPB_Clk);
    #1;
    OPB_Rst_n = 1'b0; OPB_select = 1'b0;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    checkAllIdle("rst_in_wait");
    @(posedge OPB_Clk); #1;
    OPB_Rst_n = 1'b1;
    m_tout_cnt = 0; m_last_idx = 0;
    @(posedge OPB_Clk); #1;
    doTxn("rd_after_rst", BASE + 32'h4, 1'b1, 0, 2, 32'h0BADF00D, 0, -1);

    for (int n = 0; n < 40; n++) begin
      kind     = $urandom_range(0, 6);
      rnw      = 1'($urandom);
      abort_at = -1;
      delay    = $urandom_range(0, TO + 3);
      case (kind)
        0, 1: begin
          addr = BASE + 32'($urandom_range(0, NC - 1) * 4);
          rnw  = 1'b1;
          if ($urandom_range(0, 4) == 0) abort_at = $urandom_range(1, 8);
        end
        2: begin addr = BASE + 32'($urandom_range(0, NC - 1) * 4); rnw = 1'b0; end
        3: begin addr = BASE + 32'h40; rnw = 1'b0; end
        4: addr = BASE + 32'h44;
        5: addr = BASE + 32'($urandom_range(18, 63) * 4);
        default: addr = ($urandom_range(0, 1) == 1) ? HIGH + 32'($urandom_range(1, 64) * 4)
                                                    : BASE - 32'($urandom_range(1, 64) * 4);
      endcase
      doTxn("rand", addr, rnw, $urandom, delay, $urandom, $urandom_range(0, 3), abort_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
